// File: rtl/ucie_ctl_pkg.sv
// Shared constants and types for the UCIe controller datapath.
// Flit width, beat type and pointer-width helper.
package ucie_ctl_pkg;

  localparam int NBYTES = 64;
  localparam int FLIT_W = NBYTES * 8;

  typedef logic [FLIT_W-1:0] beat_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo_mem.sv
// DEPTH x W register array: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module ucie_ctl_sync_fifo_mem
  import ucie_ctl_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = FLIT_W,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ucie_ctl_tx_buffer.sv
// TX elastic buffer from FDI to RDI: DEPTH-entry storage
// followed by an output register held until the PHY accepts.
module ucie_ctl_tx_buffer
  import ucie_ctl_pkg::*;
#(
  parameter  int NBYTES = 64,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = ptr_w(DEPTH),
  localparam int W      = NBYTES * 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_buffer_en,
  input  logic             i_flush,
  input  logic             i_fdi_lp_irdy,
  input  logic             i_fdi_lp_valid,
  input  logic [W-1:0]     i_fdi_lp_data,
  output logic             o_fdi_pl_trdy,
  output logic             o_rdi_lp_irdy,
  output logic             o_rdi_lp_valid,
  output logic [W-1:0]     o_rdi_lp_data,
  input  logic             i_rdi_pl_trdy,
  output logic [PTR_W:0]   o_count,
  output logic             o_empty,
  output logic             o_overflow_detected
);

  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0] wr_q, wr_d;
  logic [PTR_W:0] rd_q, rd_d;
  logic           vld_q, vld_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   dat_q, dat_d;
  logic [W-1:0]   rdata;
  logic [PTR_W:0] cnt;
  logic           full;
  logic           act;
  logic           push;
  logic           load;
  logic           ovf_hit;

  // Pointers wrap mod 2*DEPTH, so their difference is the fill level.
  assign cnt  = wr_q - rd_q;
  assign full = (cnt == FULL_CNT);
  assign act  = i_buffer_en & ~i_flush;

  assign o_fdi_pl_trdy = act & ~full;
  assign push = i_fdi_lp_valid & i_fdi_lp_irdy & o_fdi_pl_trdy;
  assign load = act & (cnt != '0) & (~vld_q | i_rdi_pl_trdy);
  assign ovf_hit = i_buffer_en & i_fdi_lp_valid & i_fdi_lp_irdy & full;

  ucie_ctl_sync_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_q[PTR_W-1:0]),
    .i_wdata (i_fdi_lp_data),
    .i_raddr (rd_q[PTR_W-1:0]),
    .o_rdata (rdata)
  );

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    vld_d = vld_q;
    dat_d = dat_q;
    ovf_d = ovf_q;
    if (i_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      vld_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      if (push) wr_d = wr_q + ONE;
      if (load) begin
        rd_d  = rd_q + ONE;
        dat_d = rdata;
        vld_d = 1'b1;
      end else if (vld_q & i_rdi_pl_trdy) begin
        vld_d = 1'b0;
      end
      if (ovf_hit) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_rdi_lp_valid      = vld_q;
  assign o_rdi_lp_irdy       = vld_q;
  assign o_rdi_lp_data       = dat_q;
  assign o_count             = cnt;
  assign o_empty             = (cnt == '0) & ~vld_q;
  assign o_overflow_detected = ovf_q;

endmodule

// File: tb/tb_ucie_ctl_tx_buffer.sv
// Directed bench for ucie_ctl_tx_buffer with a queue-based
// reference model checked every cycle.
module tb_ucie_ctl_tx_buffer;
  import ucie_ctl_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 64 * 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          flush;
  logic          irdy;
  logic          valid;
  logic [W-1:0]  din;
  logic          fdi_trdy;
  logic          rdi_irdy;
  logic          rdi_valid;
  logic [W-1:0]  rdi_data;
  logic          rdi_trdy;
  logic [CW-1:0] count;
  logic          empty;
  logic          ovf;

  ucie_ctl_tx_buffer #(
    .NBYTES (64),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_buffer_en         (en),
    .i_flush             (flush),
    .i_fdi_lp_irdy       (irdy),
    .i_fdi_lp_valid      (valid),
    .i_fdi_lp_data       (din),
    .o_fdi_pl_trdy       (fdi_trdy),
    .o_rdi_lp_irdy       (rdi_irdy),
    .o_rdi_lp_valid      (rdi_valid),
    .o_rdi_lp_data       (rdi_data),
    .i_rdi_pl_trdy       (rdi_trdy),
    .o_count             (count),
    .o_empty             (empty),
    .o_overflow_detected (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] a,
                     input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference model: stored beats as a queue plus the output slot.
  logic [W-1:0] mq[$];
  logic         mv;
  logic [W-1:0] md;
  logic         movf;
  bit           m_ld, m_pu, m_ov;
  int           m_sz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mv   = 1'b0;
      md   = '0;
      movf = 1'b0;
    end else if (flush) begin
      mq.delete();
      mv   = 1'b0;
      movf = 1'b0;
    end else begin
      m_sz = mq.size();
      m_ld = en && m_sz > 0 && (!mv || rdi_trdy);
      m_pu = en && valid && irdy && m_sz < DEPTH;
      m_ov = en && valid && irdy && m_sz == DEPTH;
      if (m_ld) begin
        md = mq.pop_front();
        mv = 1'b1;
      end else if (mv && rdi_trdy) begin
        mv = 1'b0;
      end
      if (m_pu) mq.push_back(din);
      if (m_ov) movf = 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("m_trdy", fdi_trdy,
          en && !flush && mq.size() < DEPTH);
      chk("m_valid", rdi_valid, mv);
      chk("m_irdy", rdi_irdy, mv);
      chk("m_count", count, mq.size());
      chk("m_empty", empty, mq.size() == 0 && !mv);
      chk("m_ovf", ovf, movf);
      if (mv) chk("m_data", rdi_data, md);
    end
  end

  // Beats actually handed to the PHY.
  logic [7:0] got[$];

  always @(posedge clk) begin
    if (!rst && !flush && rdi_valid && rdi_trdy)
      got.push_back(rdi_data[7:0]);
  end

  task automatic drv(input bit e, input bit f, input bit v,
                     input logic [7:0] d, input bit t);
    en       = e;
    flush    = f;
    valid    = v;
    irdy     = v;
    din      = '0;
    din[7:0] = d;
    rdi_trdy = t;
    @(negedge clk);
  endtask

  task automatic chk_got(input string nm, input int n,
                         input logic [7:0] base);
    chk({nm, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk(nm, got[i], base + 8'(i));
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0; flush = 1'b0; irdy = 1'b0; valid = 1'b0;
    din = '0; rdi_trdy = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", rdi_valid, 0);
    chk("rst_irdy", rdi_irdy, 0);
    chk("rst_data", rdi_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    drv(0, 0, 0, 8'h00, 0);

    // back-to-back streaming
    drv(1, 0, 1, 8'hA1, 1);
    chk("t1_valid0", rdi_valid, 0);
    chk("t1_count0", count, 1);
    drv(1, 0, 1, 8'hA2, 1);
    chk("t1_valid1", rdi_valid, 1);
    chk("t1_data1", rdi_data, 8'hA1);
    drv(1, 0, 1, 8'hA3, 1);
    chk("t1_data2", rdi_data, 8'hA2);
    drv(1, 0, 1, 8'hA4, 1);
    chk("t1_data3", rdi_data, 8'hA3);
    drv(1, 0, 0, 8'h00, 1);
    chk("t1_data4", rdi_data, 8'hA4);
    repeat (2) drv(1, 0, 0, 8'h00, 1);
    chk_got("t1_seq", 4, 8'hA1);
    chk("t1_ovf", ovf, 0);
    chk("t1_empty", empty, 1);

    // stall with PHY not ready, then overflow
    got.delete();
    for (int i = 0; i < 5; i++) drv(1, 0, 1, 8'hB1 + 8'(i), 0);
    chk("t2_trdy", fdi_trdy, 0);
    chk("t2_count", count, 4);
    chk("t2_data", rdi_data, 8'hB1);
    chk("t2_ovf0", ovf, 0);
    repeat (3) drv(1, 0, 1, 8'hEE, 0);
    chk("t3_ovf", ovf, 1);
    chk("t3_count", count, 4);
    chk("t3_data", rdi_data, 8'hB1);
    repeat (6) drv(1, 0, 0, 8'h00, 1);
    chk_got("t2_seq", 5, 8'hB1);
    chk("t3_sticky", ovf, 1);
    chk("t3_count0", count, 0);
    drv(1, 1, 0, 8'h00, 0);
    chk("t3_clr", ovf, 0);

    // steady state at count=2
    for (int i = 0; i < 3; i++) drv(1, 0, 1, 8'h10 + 8'(i), 0);
    chk("t4_count0", count, 2);
    chk("t4_data0", rdi_data, 8'h10);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 1, 8'h13 + 8'(i), 1);
      chk("t4_count", count, 2);
    end
    chk_got("t4_seq", 20, 8'h10);
    repeat (4) drv(1, 0, 0, 8'h00, 1);
    chk("t4_empty", empty, 1);

    // disable with a pending beat
    got.delete();
    drv(1, 0, 1, 8'hC1, 0);
    drv(1, 0, 1, 8'hC2, 0);
    drv(0, 0, 1, 8'hC3, 0);
    drv(0, 0, 1, 8'hC3, 0);
    chk("t5_valid", rdi_valid, 1);
    chk("t5_data", rdi_data, 8'hC1);
    chk("t5_count", count, 1);
    chk("t5_trdy", fdi_trdy, 0);
    drv(0, 0, 0, 8'h00, 1);
    chk("t5_fall", rdi_valid, 0);
    chk("t5_count1", count, 1);
    chk_got("t5_acc", 1, 8'hC1);
    repeat (3) drv(1, 0, 0, 8'h00, 1);
    chk_got("t5_seq", 2, 8'hC1);

    // flush with a simultaneous push
    for (int i = 0; i < 4; i++) drv(1, 0, 1, 8'hF1 + 8'(i), 0);
    chk("t6_count3", count, 3);
    got.delete();
    drv(1, 1, 1, 8'hF5, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_valid", rdi_valid, 0);
    repeat (3) drv(1, 0, 0, 8'h00, 1);
    chk("t6_none", got.size(), 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) drv(1, 0, 1, 8'h70 + 8'(i), 0);
    chk("t7_ovf", ovf, 1);
    chk("t7_valid", rdi_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rvalid", rdi_valid, 0);
    chk("t7_rirdy", rdi_irdy, 0);
    chk("t7_rdata", rdi_data, 0);
    chk("t7_rcount", count, 0);
    chk("t7_rempty", empty, 1);
    chk("t7_rovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    drv(1, 0, 0, 8'h00, 1);
    drv(1, 0, 1, 8'h99, 1);
    drv(1, 0, 0, 8'h00, 1);
    chk("t7_post", rdi_data, 8'h99);
    repeat (2) drv(1, 0, 0, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_tx_buffer.md
Name: ucie_ctl_tx_buffer

Overview:
- Transmit-side elastic buffer between the FDI (protocol/adapter side) and the RDI (physical-layer side) of the UCIe controller.
- Accepts flits from FDI lp_* signals under a valid/irdy/trdy handshake and stores up to DEPTH entries.
- Forwards entries in order on RDI lp_* signals, holding data stable until the PHY asserts pl_trdy.
- Mirrors the RX buffer in the opposite direction.

Parameters:
- NBYTES, 64: bytes per flit chunk; data width = NBYTES*8 bits.
- DEPTH, 4: storage entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH): pointer index width (derived, not overridable).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_buffer_en  in  1  enables accept and forward.
- i_flush  in  1  synchronous clear of all contents.
- i_fdi_lp_irdy  in  1  FDI source ready.
- i_fdi_lp_valid  in  1  FDI data valid.
- i_fdi_lp_data  in  NBYTES*8  FDI data.
- o_fdi_pl_trdy  out  1  buffer can accept this cycle.
- o_rdi_lp_irdy  out  1  RDI source ready; equals o_rdi_lp_valid.
- o_rdi_lp_valid  out  1  RDI data valid.
- o_rdi_lp_data  out  NBYTES*8  RDI data.
- i_rdi_pl_trdy  in  1  PHY accepts the current beat.
- o_count  out  PTR_W+1  entries in storage, excluding the output register.
- o_empty  out  1  storage and output register both empty.
- o_overflow_detected  out  1  sticky push-while-full flag.

Behaviour:
- Reset (i_rst=1, async): pointers=0, count=0, o_rdi_lp_valid=0, o_rdi_lp_irdy=0, o_rdi_lp_data=0, o_overflow_detected=0, o_empty=1. Memory is not reset.
- o_fdi_pl_trdy = i_buffer_en & ~i_flush & (count < DEPTH).
  - Combinational from registered count and the two inputs.
  - No path from the i_fdi_* inputs.
- push = i_fdi_lp_valid & i_fdi_lp_irdy & o_fdi_pl_trdy.
  - mem[wr_ptr] <= data.
  - wr_ptr increments by 1 and wraps modulo 2*DEPTH; the MSB distinguishes full from empty.
- Output register:
  - Load when i_buffer_en & ~i_flush & count>0 & (~o_rdi_lp_valid | i_rdi_pl_trdy).
  - On load: o_rdi_lp_data <= mem[rd_ptr], rd_ptr+1, o_rdi_lp_valid <= 1.
- Accept without reload (o_rdi_lp_valid & i_rdi_pl_trdy, no load): o_rdi_lp_valid <= 0.
- While o_rdi_lp_valid=1 and i_rdi_pl_trdy=0: o_rdi_lp_data and o_rdi_lp_valid hold unchanged.
- count update:
  - +1 on push only.
  - -1 on load only.
  - Unchanged on simultaneous push and load; this is legal at any count<DEPTH, including count=DEPTH-1.
- Latency:
  - With an idle buffer, a push at edge t gives o_rdi_lp_valid=1 after edge t+1.
  - Sustained throughput is 1 beat/cycle when i_rdi_pl_trdy stays high.
- Full (count=DEPTH):
  - o_fdi_pl_trdy=0.
  - If i_fdi_lp_valid & i_fdi_lp_irdy & i_buffer_en while full, o_overflow_detected <= 1 (sticky). Data is not written.
- Empty (count=0): no load; o_rdi_lp_valid falls after the final accept.
- i_buffer_en=0:
  - No push and no new load.
  - A beat already in the output register stays valid until accepted; valid is never dropped without trdy.
- i_flush=1:
  - Next edge: pointers=0, count=0, o_rdi_lp_valid=0, o_overflow_detected=0.
  - Flush wins over a simultaneous push, load or accept.
- Reset mid-transfer: immediately returns to the reset state; any in-flight beat is lost.
- o_empty = (count==0) & ~o_rdi_lp_valid.

Decomposition:
- Package ucie_ctl_pkg holds:
  - the flit width constant (NBYTES*8);
  - a helper function for pointer width;
  - a typedef for the data beat.
- One natural sub-module: ucie_ctl_sync_fifo_mem, a DEPTH x width register array with one write port and one asynchronous read port.
- Pointers, count, handshake and output register stay in the top module.

Test Plan:
- Reset release, i_buffer_en=1, i_rdi_pl_trdy=1, push 0xA1..0xA4 back-to-back:
  - o_rdi_lp_data is 0xA1..0xA4 on 4 consecutive cycles, starting one cycle after the first push.
  - o_overflow_detected=0.
- i_rdi_pl_trdy=0, push 5 beats 0xB1..0xB5:
  - The first beat moves to the output register, so count reaches 4.
  - o_fdi_pl_trdy=0 after the 5th push.
  - o_rdi_lp_data holds 0xB1.
  - Release trdy: 0xB2..0xB5 follow in order.
- Buffer full (DEPTH=4), keep i_fdi_lp_valid=1 & irdy=1:
  - o_overflow_detected=1 and stays set.
  - Count stays 4.
  - Cleared only by i_flush or i_rst.
- Steady state, count=2, push and accept every cycle for 20 cycles:
  - count stays 2.
  - Output sequence equals input order.
- Output valid=0xC1 with trdy=0, drop i_buffer_en:
  - 0xC1 stays valid.
  - No new push accepted.
  - After trdy, valid falls; count is unchanged.
- Assert i_flush with count=3 and a push in the same cycle:
  - Next cycle count=0, o_empty=1, o_rdi_lp_valid=0.
  - The pushed beat never appears on the output.
  - Also assert i_rst mid-stream: all outputs go to reset values asynchronously.
